// File: rtl/iopmp_cfg_pkg.sv
// rtl/iopmp_cfg_pkg.sv - shared encodings and command record for the IOPMP config sequencer
package iopmp_cfg_pkg;

  localparam logic [1:0] OP_SRCMD = 2'd0;
  localparam logic [1:0] OP_MDSEL = 2'd1;
  localparam logic [1:0] OP_ENTRY = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_CLR_ADDR = 3'd3;
  localparam logic [2:0] ST_CLR_DATA = 3'd4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef struct packed {
    logic [1:0]  op;
    logic [9:0]  idx;
    logic        ms32;
    logic [31:0] wdata;
  } cmd_t;

  // Reserved opcodes and out-of-range entry indices are dropped without a bus cycle.
  function automatic logic cmd_illegal(input cmd_t c, input logic [31:0] entry_num);
    return (c.op == OP_RSVD) || ((c.op == OP_ENTRY) && ({22'd0, c.idx} >= entry_num));
  endfunction

endpackage

// File: rtl/iopmp_cmd_fifo.sv
// rtl/iopmp_cmd_fifo.sv - small synchronous command FIFO with show-ahead read
module iopmp_cmd_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic             hclk,
  input  logic             hrst_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

  // Pointer update; reset discards any queued commands.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (pop && !empty) rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge hclk) begin
    if (push && !full) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/iopmp_cfg_sequencer.sv
// rtl/iopmp_cfg_sequencer.sv - AHB-Lite master programming the IOPMP config slave
module iopmp_cfg_sequencer
  import iopmp_cfg_pkg::*;
#(
  parameter logic [31:0] SRCID_ADDR    = 32'h4002_0000,
  parameter logic [31:0] SRCMD_ADDR    = 32'h4002_0004,
  parameter logic [31:0] MDSEL_ADDR    = 32'h4002_0008,
  parameter logic [31:0] INTR_CLR_ADDR = 32'h4002_000C,
  parameter logic [31:0] ENTRY_BASE    = 32'h4002_03A0,
  parameter int          ENTRY_NUM     = 532,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic        hclk,
  input  logic        hrst_b,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_idx,
  input  logic        cmd_ms32,
  input  logic [31:0] cmd_wdata,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic        hsel,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic        intr,
  input  logic        err_clr,
  output logic        busy,
  output logic        err,
  output logic [7:0]  viol_cnt
);

  cmd_t       fifo_din, fifo_dout, cmd_q, cmd_d;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [2:0] state_q, state_d;
  logic       beat_q, beat_d;
  logic       err_q, err_d;
  logic       intr_q, intr_pend_q, intr_pend_d;
  logic [7:0] viol_cnt_q, viol_cnt_d;
  logic       set_err, clr_done, dispatch, intr_rise;

  assign fifo_din  = {cmd_op, cmd_idx, cmd_ms32, cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign intr_rise = intr && !intr_q;

  iopmp_cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .hclk  (hclk),
    .hrst_b(hrst_b),
    .push  (cmd_valid && !fifo_full),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Transfer sequencing: interrupt clear first, otherwise pop and issue the next command.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    cmd_d    = cmd_q;
    fifo_pop = 1'b0;
    set_err  = 1'b0;
    clr_done = 1'b0;
    dispatch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (intr_pend_q) state_d = ST_CLR_ADDR;
        else             dispatch = 1'b1;
      end
      ST_ADDR: if (hready) state_d = ST_DATA;
      ST_DATA: begin
        if (hready) begin
          if (hresp == HRESP_ERROR) begin
            set_err = 1'b1;
            state_d = ST_IDLE;
          end else if ((cmd_q.op == OP_SRCMD) && !beat_q) begin
            beat_d  = 1'b1;
            state_d = ST_ADDR;
          end else begin
            state_d  = ST_IDLE;
            dispatch = !intr_pend_q;
          end
        end
      end
      ST_CLR_ADDR: if (hready) state_d = ST_CLR_DATA;
      ST_CLR_DATA: begin
        if (hready) begin
          clr_done = 1'b1;
          state_d  = ST_IDLE;
          if (hresp == HRESP_ERROR) set_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (dispatch && !fifo_empty) begin
      fifo_pop = 1'b1;
      if (cmd_illegal(fifo_dout, 32'(ENTRY_NUM))) begin
        set_err = 1'b1;
      end else begin
        cmd_d   = fifo_dout;
        beat_d  = 1'b0;
        state_d = ST_ADDR;
      end
    end
  end

  // Interrupt bookkeeping and sticky error; a set always beats a clear.
  always_comb begin
    intr_pend_d = intr_pend_q;
    if ((state_q == ST_IDLE) && (state_d == ST_CLR_ADDR)) intr_pend_d = 1'b0;
    if (intr_rise || (clr_done && intr)) intr_pend_d = 1'b1;
    viol_cnt_d = viol_cnt_q;
    if (intr_rise && (viol_cnt_q != 8'hFF)) viol_cnt_d = viol_cnt_q + 8'd1;
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (set_err) err_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state_q     <= ST_IDLE;
      beat_q      <= 1'b0;
      cmd_q       <= '0;
      err_q       <= 1'b0;
      intr_q      <= 1'b0;
      intr_pend_q <= 1'b0;
      viol_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cmd_q       <= cmd_d;
      err_q       <= err_d;
      intr_q      <= intr;
      intr_pend_q <= intr_pend_d;
      viol_cnt_q  <= viol_cnt_d;
    end
  end

  // Bus outputs decoded from the current state and latched command.
  always_comb begin
    htrans = HTRANS_IDLE;
    haddr  = 32'd0;
    hwdata = 32'd0;
    case (state_q)
      ST_ADDR: begin
        htrans = HTRANS_NONSEQ;
        case (cmd_q.op)
          OP_SRCMD: haddr = beat_q ? SRCMD_ADDR : SRCID_ADDR;
          OP_MDSEL: haddr = MDSEL_ADDR;
          default:  haddr = ENTRY_BASE + {20'd0, cmd_q.idx, 2'b00};
        endcase
      end
      ST_DATA: begin
        if ((cmd_q.op == OP_SRCMD) && !beat_q) hwdata = {cmd_q.ms32, 21'd0, cmd_q.idx};
        else                                   hwdata = cmd_q.wdata;
      end
      ST_CLR_ADDR: begin
        htrans = HTRANS_NONSEQ;
        haddr  = INTR_CLR_ADDR;
      end
      default: ;
    endcase
  end

  assign hwrite   = (htrans == HTRANS_NONSEQ);
  assign hsel     = htrans[1];
  assign hsize    = 3'b010;
  assign hprot    = 4'b0011;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign err      = err_q;
  assign viol_cnt = viol_cnt_q;

endmodule

// File: tb/tb_iopmp_cfg_sequencer.sv
// tb/tb_iopmp_cfg_sequencer.sv - self-checking bench for iopmp_cfg_sequencer
module tb_iopmp_cfg_sequencer;

  localparam logic [31:0] A_SRCID = 32'h4002_0000;
  localparam logic [31:0] A_SRCMD = 32'h4002_0004;
  localparam logic [31:0] A_MDSEL = 32'h4002_0008;
  localparam logic [31:0] A_CLR   = 32'h4002_000C;
  localparam logic [31:0] A_ENTRY = 32'h4002_03A0;

  logic        hclk = 1'b0;
  logic        hrst_b = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [9:0]  cmd_idx = 10'd0;
  logic        cmd_ms32 = 1'b0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite, hsel, busy, err;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [7:0]  viol_cnt;
  logic        hready;
  logic        hready_set = 1'b1;
  logic        rnd_ready = 1'b0;
  logic        rnd_bit = 1'b1;
  logic [1:0]  hresp = 2'b00;
  logic        intr = 1'b0;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;

  logic [31:0] mon_addr[$], mon_data[$], exp_addr[$], exp_data[$];
  logic        dp_pend = 1'b0;
  logic [31:0] dp_addr = 32'd0;

  assign hready = rnd_ready ? rnd_bit : hready_set;

  always #5 hclk = ~hclk;

  iopmp_cfg_sequencer dut (
    .hclk(hclk), .hrst_b(hrst_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_ms32(cmd_ms32), .cmd_wdata(cmd_wdata),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsel(hsel), .hsize(hsize),
    .hprot(hprot), .hwdata(hwdata), .hready(hready), .hresp(hresp), .intr(intr),
    .err_clr(err_clr), .busy(busy), .err(err), .viol_cnt(viol_cnt)
  );

  // Bus monitor: records every completed write as an (address, data) pair.
  always @(negedge hclk) begin
    if (!hrst_b) begin
      dp_pend <= 1'b0;
    end else begin
      if (dp_pend && hready) begin
        mon_addr.push_back(dp_addr);
        mon_data.push_back(hwdata);
      end
      if ((htrans == 2'b10) && hready) begin
        dp_pend <= 1'b1;
        dp_addr <= haddr;
      end else if (dp_pend && hready) begin
        dp_pend <= 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge hclk); #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge hclk); #1; end
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // Reference model: what a command should put on the bus.
  task automatic expect_cmd(input logic [1:0] op, input logic [9:0] idx, input logic ms32,
                            input logic [31:0] wd);
    int unsigned i;
    i = idx;
    case (op)
      2'd0: begin exp_w(A_SRCID, (ms32 ? 32'h8000_0000 : 32'd0) + i); exp_w(A_SRCMD, wd); end
      2'd1: exp_w(A_MDSEL, wd);
      2'd2: if (i < 532) exp_w(A_ENTRY + i * 4, wd); else exp_err = 1'b1;
      default: exp_err = 1'b1;
    endcase
  endtask

  task automatic push_raw(input logic [1:0] op, input logic [9:0] idx, input logic ms32,
                          input logic [31:0] wd);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_ms32 = ms32; cmd_wdata = wd;
    while (!cmd_ready && n < 500) begin step(1); n++; end
    if (n >= 500) chk("push_timeout", 32'(n), 32'd0);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [9:0] idx, input logic ms32,
                          input logic [31:0] wd);
    push_raw(op, idx, ms32, wd);
    expect_cmd(op, idx, ms32, wd);
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      step(1); n++;
      if (busy) quiet = 0; else quiet++;
    end
    if (n >= 3000) chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_nonseq(input string tag);
    int n = 0;
    while (htrans != 2'b10 && n < 50) begin step(1); n++; end
    chk({tag, "_nonseq"}, 32'(htrans), 32'h2);
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_count"}, 32'(mon_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < mon_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), mon_addr[i], exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), mon_data[i], exp_data[i]);
    end
    mon_addr.delete(); mon_data.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  initial begin
    logic [7:0]  v0;
    logic [1:0]  rop;
    logic [9:0]  ridx;
    logic [31:0] rwd;

    // Reset values
    step(3);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_hsel_hwrite", 32'({hsel, hwrite}), 32'd0);
    chk("rst_hsize", 32'(hsize), 32'h2);
    chk("rst_hprot", 32'(hprot), 32'h3);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy_err", 32'({busy, err}), 32'd0);
    chk("rst_viol", 32'(viol_cnt), 32'd0);
    hrst_b = 1'b1;
    step(2);

    // 1: SRCMD, two beats
    push_cmd(2'd0, 10'd3, 1'b1, 32'h0000_000F);
    wait_idle("t1");
    if (mon_data.size() > 0) chk("t1_beat0_literal", mon_data[0], 32'h8000_0003);
    cmp_writes("t1");

    // 2: ENTRY with a two-cycle address stall
    hready_set = 1'b0;
    push_cmd(2'd2, 10'd5, 1'b0, 32'hDEAD_BEEF);
    wait_nonseq("t2");
    chk("t2_haddr_c1", haddr, 32'h4002_03B4);
    chk("t2_hsel_hwrite", 32'({hsel, hwrite}), 32'h3);
    step(1);
    chk("t2_haddr_c2", haddr, 32'h4002_03B4);
    step(1);
    hready_set = 1'b1;
    chk("t2_haddr_c3", haddr, 32'h4002_03B4);
    step(1);
    chk("t2_hwdata", hwdata, 32'hDEAD_BEEF);
    chk("t2_data_htrans", 32'(htrans), 32'd0);
    wait_idle("t2");
    cmp_writes("t2");

    // 3: illegal entry index, then err clear and set-over-clear priority
    push_raw(2'd2, 10'd532, 1'b0, 32'h1234_5678);
    wait_idle("t3");
    chk("t3_err", 32'(err), 32'd1);
    cmp_writes("t3");
    err_clr = 1'b1; step(1); err_clr = 1'b0;
    chk("t3_err_clr", 32'(err), 32'd0);
    err_clr = 1'b1;
    push_raw(2'd3, 10'd0, 1'b0, 32'd0);
    step(1);
    chk("t3_set_wins", 32'(err), 32'd1);
    step(1);
    chk("t3_clr_after", 32'(err), 32'd0);
    err_clr = 1'b0;
    wait_idle("t3b");
    cmp_writes("t3b");

    // 4: interrupt serviced ahead of two queued commands
    hready_set = 1'b0;
    push_raw(2'd1, 10'd0, 1'b0, 32'hA5A5_0001);
    wait_nonseq("t4");
    push_raw(2'd2, 10'd531, 1'b0, 32'h0BAD_F00D);
    push_raw(2'd0, 10'd17, 1'b0, 32'h0000_00F0);
    intr = 1'b1; step(1); intr = 1'b0;
    expect_cmd(2'd1, 10'd0, 1'b0, 32'hA5A5_0001);
    exp_w(A_CLR, 32'd0);
    expect_cmd(2'd2, 10'd531, 1'b0, 32'h0BAD_F00D);
    expect_cmd(2'd0, 10'd17, 1'b0, 32'h0000_00F0);
    hready_set = 1'b1;
    wait_idle("t4");
    cmp_writes("t4");
    chk("t4_viol", 32'(viol_cnt), 32'd1);

    // 5: error on SRCMD beat 0 aborts beat 1
    hready_set = 1'b0;
    push_raw(2'd0, 10'd9, 1'b1, 32'hFFFF_0000);
    wait_nonseq("t5");
    hready_set = 1'b1; hresp = 2'b01;
    step(2);
    hresp = 2'b00;
    exp_w(A_SRCID, 32'h8000_0009);
    wait_idle("t5");
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    cmp_writes("t5");
    err_clr = 1'b1; step(1); err_clr = 1'b0;

    // Held interrupt counts once
    v0 = viol_cnt;
    intr = 1'b1; step(20); intr = 1'b0;
    wait_idle("hold");
    chk("hold_viol", 32'(viol_cnt), 32'(v0) + 32'd1);
    mon_addr.delete(); mon_data.delete();

    // 6: FIFO full with a stalled slave, then saturating violation count
    hready_set = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t6_ready_before%0d", k), 32'(cmd_ready), 32'd1);
      push_cmd(2'd1, 10'd0, 1'b0, 32'h6600_0000 + 32'(k));
    end
    chk("t6_full", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_wdata = 32'hBAD0_BAD0;
    step(3);
    chk("t6_held_off", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    hready_set = 1'b1;
    wait_idle("t6");
    cmp_writes("t6");
    for (int k = 0; k < 300; k++) begin intr = 1'b1; step(1); intr = 1'b0; step(1); end
    wait_idle("t6i");
    chk("t6_viol_sat", 32'(viol_cnt), 32'hFF);
    mon_addr.delete(); mon_data.delete();

    // Randomised command stream against the model
    exp_err = 1'b0;
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ridx = 10'd531;
        1: ridx = 10'd532;
        2: ridx = 10'($urandom_range(0, 531));
        default: ridx = 10'($urandom_range(533, 1023));
      endcase
      rwd = $urandom;
      push_cmd(rop, ridx, 1'($urandom_range(0, 1)), rwd);
    end
    wait_idle("rnd");
    rnd_ready = 1'b0;
    step(2);
    cmp_writes("rnd");
    chk("rnd_err", 32'(err), 32'(exp_err));

    // Reset in the middle of a transfer
    hready_set = 1'b0;
    push_raw(2'd1, 10'd0, 1'b0, 32'h1111_1111);
    push_raw(2'd1, 10'd0, 1'b0, 32'h2222_2222);
    wait_nonseq("rstm");
    hrst_b = 1'b0;
    #1;
    chk("rstm_htrans", 32'(htrans), 32'd0);
    chk("rstm_busy_ready", 32'({busy, cmd_ready}), 32'd1);
    chk("rstm_viol_err", 32'({viol_cnt, err}), 32'd0);
    step(1);
    hrst_b = 1'b1;
    hready_set = 1'b1;
    step(10);
    cmp_writes("rstm");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
